// File: rtl/eth_phy_10g_pkg.sv
// eth_phy_10g_pkg: shared 64b/66b sync-header constants,
// header classifier and the block-lock FSM state type.
package eth_phy_10g_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef enum logic [1:0] {
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT
  } lock_state_e;

  function automatic logic sh_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/gt_rx_block_lock_if.sv
// gt_rx_block_lock_if: GT rx header / slip bundle plus
// the lock status seen by the rx PCS.
interface gt_rx_block_lock_if #(
  parameter int CNT_WIDTH = 16
);
  logic [1:0]           serdes_rx_hdr;
  logic                 serdes_rx_hdr_valid;
  logic                 serdes_rx_bitslip;
  logic                 rx_block_lock;
  logic                 rx_high_ber;
  logic [CNT_WIDTH-1:0] rx_slip_count;
  logic [CNT_WIDTH-1:0] rx_sh_err_count;

  modport master (
    output serdes_rx_hdr,
    output serdes_rx_hdr_valid,
    input  serdes_rx_bitslip,
    input  rx_block_lock,
    input  rx_high_ber,
    input  rx_slip_count,
    input  rx_sh_err_count
  );

  modport slave (
    input  serdes_rx_hdr,
    input  serdes_rx_hdr_valid,
    output serdes_rx_bitslip,
    output rx_block_lock,
    output rx_high_ber,
    output rx_slip_count,
    output rx_sh_err_count
  );
endinterface

// File: rtl/gt_rx_ber_monitor.sv
// gt_rx_ber_monitor: counts invalid headers per fixed window
// while locked and flags high BER until a clean window wraps.
module gt_rx_ber_monitor #(
  parameter int BER_WINDOW      = 19531,
  parameter int BER_INVALID_MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic sh_invalid_i,
  output logic rx_high_ber_o
);
  localparam int TW = $clog2(BER_WINDOW + 1);
  localparam int CW = $clog2(BER_INVALID_MAX + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hb_q, hb_d;
  logic          wrap;
  logic          full;

  assign wrap = (timer_q == TW'(BER_WINDOW - 1));
  assign full = (cnt_q >= CW'(BER_INVALID_MAX));

  // window timer, invalid count and flag update
  always_comb begin
    timer_d = timer_q + 1'b1;
    cnt_d   = cnt_q;
    hb_d    = hb_q;
    if (!enable_i) begin
      timer_d = '0;
      cnt_d   = '0;
      hb_d    = 1'b0;
    end else if (wrap) begin
      timer_d = '0;
      cnt_d   = CW'(sh_invalid_i);
      hb_d    = full;
    end else begin
      if (sh_invalid_i && !full) begin
        cnt_d = cnt_q + 1'b1;
      end
      hb_d = hb_q | full;
    end
  end

  // monitor state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      cnt_q   <= '0;
      hb_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      hb_q    <= hb_d;
    end
  end

  assign rx_high_ber_o = hb_q;

endmodule

// File: rtl/gt_rx_block_lock.sv
// gt_rx_block_lock: 64b/66b sync-header lock FSM with gearbox
// slip control and status counters; BER monitor runs while locked.
module gt_rx_block_lock
  import eth_phy_10g_pkg::*;
#(
  parameter int SH_CNT_MAX      = 64,
  parameter int SH_INVALID_MAX  = 16,
  parameter int SLIP_WAIT       = 32,
  parameter int BER_WINDOW      = 19531,
  parameter int BER_INVALID_MAX = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst_n,
  gt_rx_block_lock_if.slave bus
);
  localparam int SHW = $clog2(SH_CNT_MAX + 1);
  localparam int INW = $clog2(SH_INVALID_MAX + 1);
  localparam int WW  = $clog2(SLIP_WAIT + 1);

  lock_state_e          state_q, state_d;
  logic [SHW-1:0]       sh_cnt_q, sh_cnt_d;
  logic [INW-1:0]       sh_inv_q, sh_inv_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 lock_q, lock_d;
  logic                 slip_q, slip_d;
  logic [CNT_WIDTH-1:0] slip_cnt_q, slip_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 hdr_eval;
  logic                 hdr_bad;
  logic                 inv_strobe;
  logic                 high_ber;

  assign hdr_eval   = bus.serdes_rx_hdr_valid;
  assign hdr_bad    = !sh_valid(bus.serdes_rx_hdr);
  assign inv_strobe = (state_q == ST_TEST_SH)
                    && hdr_eval && hdr_bad;

  // FSM state and window counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET_CNT;
      sh_cnt_q <= '0;
      sh_inv_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      sh_inv_q <= sh_inv_d;
      wait_q   <= wait_d;
    end
  end

  // lock decisions on each qualified header
  always_comb begin
    state_d  = state_q;
    sh_cnt_d = sh_cnt_q;
    sh_inv_d = sh_inv_q;
    wait_d   = wait_q;
    unique case (state_q)
      ST_RESET_CNT: begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        state_d  = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (hdr_eval) begin
          sh_cnt_d = sh_cnt_q + 1'b1;
          sh_inv_d = sh_inv_q + INW'(hdr_bad);
          if (!lock_q) begin
            if (hdr_bad) begin
              state_d = ST_SLIP;
            end else if (sh_cnt_d == SHW'(SH_CNT_MAX)
                         && sh_inv_q == '0) begin
              state_d = ST_RESET_CNT;
            end
          end else if (hdr_bad
                       && sh_inv_d == INW'(SH_INVALID_MAX)) begin
            state_d = ST_SLIP;
          end else if (sh_cnt_d == SHW'(SH_CNT_MAX)) begin
            state_d = ST_RESET_CNT;
          end
        end
      end
      ST_SLIP: begin
        wait_d  = '0;
        state_d = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WW'(SLIP_WAIT - 1)) begin
          state_d = ST_RESET_CNT;
        end
      end
      default: state_d = ST_RESET_CNT;
    endcase
  end

  // lock flag, slip pulse and saturating status counters
  always_comb begin
    lock_d     = lock_q;
    slip_d     = (state_d == ST_SLIP);
    slip_cnt_d = slip_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (state_d == ST_SLIP) begin
      lock_d = 1'b0;
    end else if (state_q == ST_TEST_SH
                 && state_d == ST_RESET_CNT) begin
      lock_d = 1'b1;
    end
    if (slip_d && slip_cnt_q != '1) begin
      slip_cnt_d = slip_cnt_q + 1'b1;
    end
    if (inv_strobe && lock_q && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      slip_cnt_q <= slip_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  gt_rx_ber_monitor #(
    .BER_WINDOW      (BER_WINDOW),
    .BER_INVALID_MAX (BER_INVALID_MAX)
  ) u_ber (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (lock_q),
    .sh_invalid_i  (inv_strobe),
    .rx_high_ber_o (high_ber)
  );

  assign bus.serdes_rx_bitslip = slip_q;
  assign bus.rx_block_lock     = lock_q;
  assign bus.rx_high_ber       = high_ber;
  assign bus.rx_slip_count     = slip_cnt_q;
  assign bus.rx_sh_err_count   = err_cnt_q;

endmodule

// File: tb/tb_gt_rx_block_lock.sv
// tb_gt_rx_block_lock: directed header streams with
// hand-computed lock, slip and BER expectations.
module tb_gt_rx_block_lock;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   slips = 0;

  gt_rx_block_lock_if #(.CNT_WIDTH(16)) bus ();

  gt_rx_block_lock #(
    .BER_WINDOW (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [1:0] vh(input int k);
    return k[0] ? 2'b01 : 2'b10;
  endfunction

  task automatic step(input logic [1:0] h, input logic v);
    bus.serdes_rx_hdr       = h;
    bus.serdes_rx_hdr_valid = v;
    @(posedge clk);
    #1;
    if (bus.serdes_rx_bitslip === 1'b1) slips++;
  endtask

  task automatic do_reset(input string tag, input int ncyc);
    rst_n = 1'b0;
    #1;
    check({tag, "_slip"}, bus.serdes_rx_bitslip, 0);
    check({tag, "_lock"}, bus.rx_block_lock, 0);
    check({tag, "_hber"}, bus.rx_high_ber, 0);
    check({tag, "_slipcnt"}, bus.rx_slip_count, 0);
    check({tag, "_errcnt"}, bus.rx_sh_err_count, 0);
    repeat (ncyc) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slips = 0;
  endtask

  task automatic aligned(input string tag);
    for (int k = 1; k <= 65; k++) begin
      step(vh(k), 1'b1);
      if (k == 1)
        check({tag, "_noslip_rel"}, bus.serdes_rx_bitslip, 0);
      if (k == 64)
        check({tag, "_lock64"}, bus.rx_block_lock, 0);
      if (k == 65) begin
        check({tag, "_lock65"}, bus.rx_block_lock, 1);
        check({tag, "_slipcnt"}, bus.rx_slip_count, 0);
      end
    end
    check({tag, "_pulses"}, slips, 0);
  endtask

  initial begin
    logic [1:0] h;
    logic       v;
    rst_n = 1'b1;
    bus.serdes_rx_hdr = 2'b00;
    bus.serdes_rx_hdr_valid = 1'b0;
    #2;
    do_reset("rst0", 2);

    // aligned stream: header at release cycle is dropped
    aligned("t1");

    // reset while locked, then reset in SLIP_WAIT
    do_reset("rst_lock", 1);
    for (int k = 1; k <= 10; k++) begin
      step((k == 2) ? 2'b00 : vh(k), 1'b1);
      if (k == 2) begin
        check("rw_slip", bus.serdes_rx_bitslip, 1);
        check("rw_slipcnt", bus.rx_slip_count, 1);
      end
    end
    do_reset("rst_wait", 1);
    aligned("t1b");

    // misaligned: slips at 2, 37, 72; junk in SLIP_WAIT
    do_reset("rst2", 2);
    for (int k = 1; k <= 170; k++) begin
      if (k == 2 || k == 37 || k == 72) h = 2'b00;
      else if (k == 10 || k == 45) h = 2'b11;
      else h = vh(k);
      step(h, 1'b1);
      if (k == 2 || k == 37 || k == 72)
        check("t2_slip_hi", bus.serdes_rx_bitslip, 1);
      if (k == 3 || k == 38 || k == 73)
        check("t2_slip_lo", bus.serdes_rx_bitslip, 0);
      if (k == 72) check("t2_slipcnt", bus.rx_slip_count, 3);
      if (k == 169) check("t2_lock169", bus.rx_block_lock, 0);
      if (k == 170) check("t2_lock170", bus.rx_block_lock, 1);
    end
    check("t2_pulses", slips, 3);

    // locked tolerance: 15 bad, then 16 bad in next window
    for (int k = 171; k <= 256; k++) begin
      if ((k >= 180 && k <= 194) || (k >= 240 && k <= 255))
        h = 2'b00;
      else h = vh(k);
      step(h, 1'b1);
      if (k == 194) check("t3_err15", bus.rx_sh_err_count, 15);
      if (k == 235) check("t3_lock_win", bus.rx_block_lock, 1);
      if (k == 250) check("t3_hber", bus.rx_high_ber, 1);
      if (k == 254) begin
        check("t3_lock254", bus.rx_block_lock, 1);
        check("t3_err30", bus.rx_sh_err_count, 30);
      end
      if (k == 255) begin
        check("t3_lock_drop", bus.rx_block_lock, 0);
        check("t3_slip", bus.serdes_rx_bitslip, 1);
        check("t3_slipcnt", bus.rx_slip_count, 4);
        check("t3_err31", bus.rx_sh_err_count, 31);
      end
      if (k == 256) begin
        check("t3_slip_lo", bus.serdes_rx_bitslip, 0);
        check("t3_hber_off", bus.rx_high_ber, 0);
      end
    end
    check("t3_pulses", slips, 4);

    // hdr_valid gaps with 2'b11 on unqualified cycles
    do_reset("rst4", 2);
    for (int k = 1; k <= 128; k++) begin
      v = (k % 2 == 0);
      step(v ? vh(k) : 2'b11, v);
      if (k == 127) check("t4_lock127", bus.rx_block_lock, 0);
      if (k == 128) begin
        check("t4_lock128", bus.rx_block_lock, 1);
        check("t4_slipcnt", bus.rx_slip_count, 0);
      end
    end
    check("t4_pulses", slips, 0);

    // BER: 16 bad in first window, 2 bad in second
    do_reset("rst5", 2);
    for (int k = 1; k <= 265; k++) begin
      if ((k >= 75 && k <= 82) || (k >= 135 && k <= 142)
          || k == 185 || k == 186)
        h = 2'b00;
      else h = vh(k);
      step(h, 1'b1);
      if (k == 65) check("t5_lock", bus.rx_block_lock, 1);
      if (k == 142) check("t5_hber142", bus.rx_high_ber, 0);
      if (k == 143) check("t5_hber143", bus.rx_high_ber, 1);
      if (k == 165) check("t5_hber_wrap1", bus.rx_high_ber, 1);
      if (k == 186) check("t5_err18", bus.rx_sh_err_count, 18);
      if (k == 264) check("t5_hber264", bus.rx_high_ber, 1);
      if (k == 265) begin
        check("t5_hber_wrap2", bus.rx_high_ber, 0);
        check("t5_lock_kept", bus.rx_block_lock, 1);
      end
    end
    check("t5_pulses", slips, 0);

    // reset while locked with nonzero error count
    do_reset("rst6", 1);
    aligned("t6");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gt_rx_block_lock.md
Name: gt_rx_block_lock

Overview:
- Receive-side alignment responder for the GTH 64b/66b gearbox.
- Watches the 2-bit sync header delivered with each valid GT word, and pulses rxgearboxslip until headers line up.
- Asserts block lock per the IEEE 802.3 clause 49 lock state machine, and runs a 125 us high-BER monitor.
- Sits between the GT rx header outputs and the rx PCS of each SFP+ lane.

Parameters:
- SH_CNT_MAX, 64: valid-header count that closes one test window.
- SH_INVALID_MAX, 16: invalid headers within one test window that cause loss of lock while locked.
- SLIP_WAIT, 32: clk cycles ignored after each bitslip pulse, to let the gearbox settle.
- BER_WINDOW, 19531: clk cycles per BER window (125 us at 156.25 MHz).
- BER_INVALID_MAX, 16: invalid headers within one BER window that set high BER.
- CNT_WIDTH, 16: width of the status counters.

Ports:
- clk, input, 1: GT rx user clock; all logic on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- serdes_rx_hdr, input, 2: sync header of the current word.
- serdes_rx_hdr_valid, input, 1: header qualifier (GT rxheadervalid bit 0).
- serdes_rx_bitslip, output, 1: one-cycle slip request to the GT rxgearboxslip.
- rx_block_lock, output, 1: block lock status.
- rx_high_ber, output, 1: high bit-error-rate status.
- rx_slip_count, output, CNT_WIDTH: slips issued; saturating.
- rx_sh_err_count, output, CNT_WIDTH: invalid headers seen while locked; saturating.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, all counters 0, FSM in RESET_CNT. Reset at any time, including mid-slip or mid-window, aborts immediately. No slip pulse may be emitted in the cycle rst_n deasserts.
- Header classification:
  - A header is valid when serdes_rx_hdr is 2'b01 or 2'b10.
  - 2'b00 and 2'b11 are invalid.
  - Only cycles with serdes_rx_hdr_valid=1 are evaluated. Other cycles change no counters except the SLIP_WAIT and BER timers.
- FSM states: RESET_CNT, TEST_SH, SLIP, SLIP_WAIT.
  - RESET_CNT: clear sh_cnt and sh_invalid_cnt. Go to TEST_SH the next cycle.
  - TEST_SH, per evaluated header:
    - sh_cnt increments on every evaluated header.
    - An invalid header increments sh_invalid_cnt.
    - Not locked, invalid header: go to SLIP.
    - Not locked, sh_cnt reaches SH_CNT_MAX with 0 invalid headers: set rx_block_lock, go to RESET_CNT.
    - Locked, sh_invalid_cnt reaches SH_INVALID_MAX: clear rx_block_lock, go to SLIP. This takes priority over window completion on the same header.
    - Locked, sh_cnt reaches SH_CNT_MAX with sh_invalid_cnt below SH_INVALID_MAX: go to RESET_CNT, lock retained.
  - SLIP: drive serdes_rx_bitslip=1 for exactly one cycle, increment rx_slip_count, go to SLIP_WAIT.
  - SLIP_WAIT: count SLIP_WAIT cycles regardless of hdr_valid, then go to RESET_CNT. Headers in this state are ignored.
- Slip spacing: at most one slip per SLIP_WAIT+2 cycles.
- Lock timing: rx_block_lock rises in the cycle after the 64th consecutive valid evaluated header. It falls in the cycle after the 16th invalid header of a window.
- rx_sh_err_count increments on each invalid evaluated header while rx_block_lock=1 and the FSM is in TEST_SH.
- Both status counters saturate at all-ones; they never wrap.
- BER monitor:
  - Active only while rx_block_lock=1. While unlocked, the timer and ber_cnt are held at 0 and rx_high_ber is 0.
  - The timer counts 0..BER_WINDOW-1 and wraps.
  - ber_cnt counts invalid evaluated headers.
  - rx_high_ber sets in the cycle after ber_cnt reaches BER_INVALID_MAX.
  - At timer wrap: ber_cnt clears. rx_high_ber clears only if ber_cnt < BER_INVALID_MAX at that wrap.
  - An invalid header on the wrap cycle counts toward the new window.
- Latency: header input to FSM decision is 1 cycle. All outputs are registered.

Decomposition:
- Shared package eth_phy_10g_pkg:
  - Constants SYNC_DATA=2'b10 and SYNC_CTRL=2'b01.
  - Function sh_valid(hdr).
  - FSM state enum for this block.
- One sub-module: gt_rx_ber_monitor, holding the timer, ber_cnt and rx_high_ber. Inputs are clk, rst_n, enable=rx_block_lock and an invalid-header strobe. Output is rx_high_ber.
- FSM and status counters stay in gt_rx_block_lock.

Test Plan:
- Aligned stream: continuous hdr 2'b01/2'b10 with hdr_valid=1 from reset release -> no bitslip; rx_block_lock=1 one cycle after the 64th header; rx_slip_count=0.
- Misaligned then aligned: 3 invalid headers spaced more than SLIP_WAIT+2 cycles apart, then 64 valid -> exactly 3 one-cycle bitslip pulses; rx_slip_count=3; lock after the 64th valid header; headers during SLIP_WAIT are ignored.
- Locked tolerance: 15 invalid among 64 headers -> lock held; rx_sh_err_count=15. Next window with 16 invalid -> lock drops one cycle after the 16th invalid, one slip pulse, rx_high_ber=0.
- hdr_valid gaps: valid headers with hdr_valid toggling 1/0 and 2'b11 presented on the invalid cycles -> 2'b11 ignored; lock after 64 qualified headers (about 128 cycles).
- BER: locked, BER_WINDOW=100; 16 invalid headers within one window, spread so lock is kept -> rx_high_ber=1. Next window with 2 invalid headers -> rx_high_ber=0 after that window's wrap.
- Reset mid-operation: assert rst_n low for 1 cycle while in SLIP_WAIT and while locked -> all outputs 0 immediately. After release, behaviour restarts as in the aligned-stream scenario.
